// File: rtl/fsm_stim_pkg.sv
// Shared types and helpers for the serial stimulus stage and the 1011 detector bench.
package fsm_stim_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic DEF_IDLE_LEVEL = 1'b0;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((64'(1) << r) < 64'(n)) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage: accepts WIDTH-bit words on valid/ready and emits
// one bit per clock on xout, allowing gapless back-to-back words.
module bit_serializer
  import fsm_stim_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = DEF_IDLE_LEVEL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             xout,
  output logic             xout_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int             CW       = clog2_min1(WIDTH);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d, sreg_nxt;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             xout_q, xout_d;
  logic             xv_q, xv_d;
  logic             last_q, last_d;
  logic             cnt_zero, accept;

  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  assign cnt_zero = (cnt_q == '0);
  assign accept   = din_valid && din_ready;
  // Shift toward whichever end feeds xout.
  assign sreg_nxt = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (cnt_zero && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready while idle, or while the final bit of the current word is on xout.
  always_comb begin
    din_ready = (state_q == IDLE) || ((state_q == SHIFT) && cnt_zero);
    busy      = (state_q == SHIFT);
  end

  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    xout_d = xout_q;
    xv_d   = xv_q;
    last_d = last_q;
    if (accept) begin
      sreg_d = din;
      xout_d = out_bit(din);
      xv_d   = 1'b1;
      cnt_d  = CNT_LOAD;
      last_d = (WIDTH == 1);
    end else if (state_q == SHIFT && !cnt_zero) begin
      sreg_d = sreg_nxt;
      xout_d = out_bit(sreg_nxt);
      xv_d   = 1'b1;
      cnt_d  = cnt_q - CW'(1);
      last_d = (cnt_q == CW'(1));
    end else if (state_q == SHIFT) begin
      xout_d = IDLE_LEVEL;
      xv_d   = 1'b0;
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      xout_q <= IDLE_LEVEL;
      xv_q   <= 1'b0;
      last_q <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      xout_q <= xout_d;
      xv_q   <= xv_d;
      last_q <= last_d;
    end
  end

  assign xout       = xout_q;
  assign xout_valid = xv_q;
  assign last_bit   = last_q;

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial stimulus stage that sits directly upstream of the 1011 sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on xout.
- xout drives the detector's xin input.
- Supports gapless back-to-back words, so one continuous serial stream can span word boundaries. This matters because detector patterns may straddle two words.

Parameters:
- WIDTH, 8: bits per word; legal range 1..32.
- MSB_FIRST, 1: 1 = transmit din[WIDTH-1] first; 0 = transmit din[0] first.
- IDLE_LEVEL, 0: value driven on xout while no word is being sent.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  parallel word to serialize; sampled only on an accept edge.
- din_valid  input  1  producer has a word on din.
- din_ready  output  1  block can accept a word this cycle (combinational).
- xout  output  1  serial bit, registered; connects to the detector's xin.
- xout_valid  output  1  xout carries a real data bit this cycle (registered).
- last_bit  output  1  xout carries the final bit of the current word (registered).
- busy  output  1  state is SHIFT.

Behaviour:
- **Reset values:**
  - state = IDLE, cnt = 0, sreg = 0.
  - xout = IDLE_LEVEL, xout_valid = 0, last_bit = 0.
  - din_ready goes to 1 immediately, since it is combinational.
- **Accept:** occurs on a rising edge with din_valid && din_ready.
- **din_ready:** = (state == IDLE) || (state == SHIFT && cnt == 0).
  - This lets a new word be accepted in the same cycle the last bit of the current word is on xout.
- **States:**
  - IDLE: no word in flight.
  - SHIFT: a word is in flight.
- **On an accept edge (from IDLE, or from SHIFT with cnt == 0):**
  - sreg loads din.
  - xout gets the first bit (din[WIDTH-1] if MSB_FIRST, else din[0]).
  - xout_valid = 1.
  - cnt = WIDTH-1 (number of bits still to send after this one).
  - last_bit = (WIDTH == 1).
  - Next state = SHIFT.
- **SHIFT with cnt > 0:**
  - sreg shifts toward the output end.
  - xout = next bit; cnt decrements.
  - last_bit = 1 when the new cnt == 0.
  - din_valid is ignored (din_ready = 0).
- **SHIFT with cnt == 0 and no accept:**
  - Next state = IDLE.
  - xout = IDLE_LEVEL, xout_valid = 0, last_bit = 0.
- **Latency:** the first bit appears on xout in the cycle after the accept edge.
  - Word k occupies exactly WIDTH consecutive cycles.
  - Back-to-back words have no bubble.
- **cnt width:** clog2(WIDTH) bits, minimum 1; cnt never underflows.
- **din changing while din_ready = 0:** no effect; the in-flight word is unaffected.
- **din_valid deasserted mid-word:** no effect. The word always completes once accepted; there is no abort input.
- **rst asserted mid-word:**
  - All registers return to reset values asynchronously.
  - The partially sent word is discarded and not resumed.
  - The first accept after reset release starts a fresh word.
- **WIDTH == 1:**
  - Every word is a single-cycle last_bit.
  - Continuous din_valid gives one bit per clock with xout_valid held at 1.

Decomposition:
- Shared package fsm_stim_pkg:
  - State enum {IDLE, SHIFT}.
  - Constant IDLE_LEVEL default.
  - clog2 helper function; the detector bench reuses the package.
- No sub-module; a single module of about 150 lines.
- The integration bench instantiates bit_serializer feeding moore_fsm_1011.

Test Plan:
- Reset check: rst = 1 for 2 cycles, then released, with din_valid = 0 → xout = 0, xout_valid = 0, last_bit = 0, busy = 0, din_ready = 1 throughout.
- Single word, WIDTH = 8, MSB_FIRST = 1, din = 8'hB5 held valid for one accept → xout = 1,0,1,1,0,1,0,1 on 8 consecutive cycles; last_bit only on the 8th; then xout_valid = 0 and din_ready stays 1.
- Back-to-back, WIDTH = 4, din_valid held high with 4'hB then 4'h6 → 8 gapless bits 1,0,1,1,0,1,1,0; din_ready high only in IDLE and on cycles 4 and 8; xout_valid never drops between words.
- LSB order, MSB_FIRST = 0, din = 8'h0D → xout = 1,0,1,1,0,0,0,0.
- Mid-word reset: accept 8'hFF, assert rst after the 3rd bit → xout = 0 and xout_valid = 0 immediately (asynchronous). The next accept of 8'h80 yields 1,0,0,0,0,0,0,0 with no leftover bits.
- Integration with moore_fsm_1011, WIDTH = 4: stream 4'hB, 4'hB gapless → detector zout asserts after the 4th bit and again after the 8th bit.
